// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller between the bus-side plaintext FIFO and the
// single-block DES core. Each accepted plaintext block is optionally XORed
// with the chaining value (CBC) and handed to the core with a one-cycle start
// pulse. The core result is then returned on the ciphertext stream. Only one
// block is in flight at a time. A watchdog drops the block and raises a sticky
// error if the core does not answer.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_load/key/iv/cbc      configuration latch (taken only while idle)
//   in_valid/ready/data/last plaintext stream
//   out_valid/ready/data/last ciphertext stream
//   core_start/din/key       command to the DES core
//   core_ready/dout          DES core completion pulse and result
//   busy, err, blk_cnt       status: not idle, sticky timeout, blocks completed
// -----------------------------------------------------------------------------
module des_cbc_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [63:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_cbc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic             core_start,
  output logic [63:0]      core_din,
  output logic [63:0]      core_key,
  input  logic             core_ready,
  input  logic [63:0]      core_dout,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  // The watchdog is cleared in START and reads 0 in the first WAIT cycle, so
  // it becomes TIMEOUT_CYC-1 on the same edge that raises err when it is
  // seen at TIMEOUT_CYC-2 without a core answer. err is then visible exactly
  // TIMEOUT_CYC cycles after the core_start cycle.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wdog;
  logic [63:0]       key_q, iv_q, chain_q;
  logic              cbc_q, last_q;
  logic              cfg_take, accept, core_done, timeout, out_fire;

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_take  = 1'b0;
    accept    = 1'b0;
    core_done = 1'b0;
    timeout   = 1'b0;
    out_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        // cfg_load wins over a simultaneous input block
        cfg_take = cfg_load;
        in_ready = !cfg_load && !rst;
        accept   = in_valid && in_ready;
        if (accept) state_nxt = S_START;
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        core_done = core_ready;
        timeout   = !core_ready && (wdog == WD_LIMIT);
        if (core_done)    state_nxt = S_OUT;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_OUT: begin
        out_fire = out_ready;
        if (out_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign core_start = (state == S_START);
  assign out_valid  = (state == S_OUT);
  assign busy       = (state != S_IDLE);
  assign core_key   = key_q;

  // State, configuration, chaining and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wdog     <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      chain_q  <= '0;
      cbc_q    <= 1'b0;
      last_q   <= 1'b0;
      core_din <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      err      <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (cfg_take) begin
        key_q   <= cfg_key;
        iv_q    <= cfg_iv;
        cbc_q   <= cfg_cbc;
        chain_q <= cfg_iv;
        blk_cnt <= '0;
        err     <= 1'b0;
      end

      if (accept) begin
        core_din <= cbc_q ? (in_data ^ chain_q) : in_data;
        last_q   <= in_last;
      end

      if (state == S_START)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + WD_W'(1);

      if (core_done) begin
        out_data <= core_dout;
        out_last <= last_q;
        // End of a CBC message restarts the chain from the IV
        if (cbc_q) chain_q <= last_q ? iv_q : core_dout;
      end

      if (timeout) err <= 1'b1;

      if (out_fire) blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Testbench for des_cbc_ctrl: directed scenarios followed by a randomized
// block stream, checked against a message-level model of ECB/CBC chaining.
module tb_des_cbc_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;
  localparam logic [63:0] K_STD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] P_STD  = 64'h0123456789ABCDEF;
  localparam logic [63:0] C_STD  = 64'h85E813540F0AB405;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [63:0]   cfg_key, cfg_iv;
  logic          cfg_cbc;
  logic          in_valid, in_ready, in_last;
  logic [63:0]   in_data;
  logic          out_valid, out_ready, out_last;
  logic [63:0]   out_data;
  logic          core_start, core_ready;
  logic [63:0]   core_din, core_key, core_dout;
  logic          busy, err;
  logic [CW-1:0] blk_cnt;

  des_cbc_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_cbc(cfg_cbc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_din(core_din), .core_key(core_key),
    .core_ready(core_ready), .core_dout(core_dout),
    .busy(busy), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: the configuration and chaining value of the message
  logic [63:0] key_m, iv_m, chain_m;
  logic        cbc_m, err_m;
  int          cnt_m;
  logic [63:0] seen_din, seen_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Stand-in for the DES core: the standard test vector, otherwise a keyed mix
  function automatic logic [63:0] core_fn(input logic [63:0] din, input logic [63:0] key);
    if (din == P_STD && key == K_STD) return C_STD;
    return {din[31:0], din[63:32]} ^ key ^ 64'hA5C3_5A3C_0F1E_2D4B;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_cfg(input logic [63:0] k, input logic [63:0] iv, input logic cbc);
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv; cfg_cbc = cbc;
    #1;
    chk("in_ready_cfg", in_ready, 0);
    tick;
    cfg_load = 1'b0; cfg_key = {$urandom, $urandom}; cfg_iv = {$urandom, $urandom};
    key_m = k; iv_m = iv; chain_m = iv; cbc_m = cbc; err_m = 1'b0; cnt_m = 0;
    chk("blk_cnt_cfg", blk_cnt, 0);
    chk("err_cfg", err, 0);
  endtask

  task automatic send_block(input logic [63:0] p, input logic last, input int dly, input int hold);
    logic [63:0] din_e, ct_e;
    din_e = cbc_m ? (p ^ chain_m) : p;
    ct_e  = core_fn(din_e, key_m);
    in_valid = 1'b1; in_data = p; in_last = last;
    #1;
    chk("in_ready_idle", in_ready, 1);
    tick;
    in_valid = 1'b0; in_data = {$urandom, $urandom}; in_last = $urandom_range(0, 1);
    #1;
    chk("core_start_hi", core_start, 1);
    chk("core_din", core_din, din_e);
    chk("core_key", core_key, key_m);
    chk("busy_start", busy, 1);
    chk("in_ready_start", in_ready, 0);
    seen_din = core_din;
    tick;
    chk("core_start_pulse", core_start, 0);
    repeat (dly - 1) tick;
    chk("core_din_hold", core_din, din_e);
    chk("out_valid_wait", out_valid, 0);
    core_ready = 1'b1; core_dout = ct_e;
    tick;
    core_ready = 1'b0; core_dout = {$urandom, $urandom};
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, ct_e);
    chk("out_last", out_last, last);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      core_ready = $urandom_range(0, 1);
      tick;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, ct_e);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_core_start", core_start, 0);
    end
    in_valid = 1'b0; core_ready = 1'b0;
    seen_out = out_data;
    if (cbc_m) chain_m = last ? iv_m : ct_e;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    cnt_m = (cnt_m + 1) % (1 << CW);
    chk("out_valid_done", out_valid, 0);
    chk("blk_cnt", blk_cnt, cnt_m);
    chk("busy_done", busy, 0);
    chk("err_done", err, err_m);
  endtask

  task automatic send_timeout(input logic [63:0] p);
    logic [63:0] din_e;
    din_e = cbc_m ? (p ^ chain_m) : p;
    in_valid = 1'b1; in_data = p; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("to_core_start", core_start, 1);
    chk("to_core_din", core_din, din_e);
    for (int i = 1; i < TO; i++) begin
      tick;
      chk("to_err_early", err, err_m);
      chk("to_busy", busy, 1);
    end
    tick;
    err_m = 1'b1;
    chk("to_err", err, 1);
    chk("to_busy_idle", busy, 0);
    chk("to_out_valid", out_valid, 0);
    chk("to_blk_cnt", blk_cnt, cnt_m);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] p;
    rst = 1'b1; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    core_ready = 1'b0; core_dout = '0;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    rst = 1'b0;

    // ECB with the standard DES vector
    do_cfg(K_STD, 64'h0, 1'b0);
    send_block(P_STD, 1'b0, 3, 0);
    chk("ecb_din", seen_din, P_STD);
    chk("ecb_out", seen_out, C_STD);
    chk("ecb_cnt", blk_cnt, 1);

    // CBC chaining from a zero IV
    do_cfg(K_STD, 64'h0, 1'b1);
    send_block(P_STD, 1'b0, 2, 0);
    send_block(P_STD, 1'b0, 4, 1);
    chk("cbc_din2", seen_din, 64'h84CB563386A179EA);

    // in_last restarts the chain from the IV
    do_cfg(K_STD, 64'h1111111111111111, 1'b1);
    send_block({$urandom, $urandom}, 1'b1, 1, 0);
    p = {$urandom, $urandom};
    send_block(p, 1'b0, TO - 1, 0);
    chk("last_reload_din", seen_din, p ^ 64'h1111111111111111);

    // Backpressure
    send_block({$urandom, $urandom}, 1'b0, 2, 10);

    // Timeout, then normal operation with err still set
    send_timeout({$urandom, $urandom});
    send_block({$urandom, $urandom}, 1'b1, 3, 0);
    chk("err_sticky", err, 1);

    // Randomized stream; long enough to wrap the block counter
    do_cfg({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) send_timeout({$urandom, $urandom});
      else send_block({$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                      $urandom_range(1, TO - 1), $urandom_range(0, 3));
    end

    // cfg_load beats a simultaneous input block
    p = {$urandom, $urandom};
    in_valid = 1'b1; in_data = p; in_last = 1'b0;
    do_cfg({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    chk("prio_busy", busy, 0);
    send_block(p, 1'b0, 2, 0);

    // Reset in WAIT; a late core_ready must be ignored
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    tick;
    in_valid = 1'b0;
    tick;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick;
    chk("wrst_in_ready", in_ready, 0);
    chk("wrst_out_valid", out_valid, 0);
    chk("wrst_out_data", out_data, 0);
    chk("wrst_core_start", core_start, 0);
    chk("wrst_core_din", core_din, 0);
    chk("wrst_core_key", core_key, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_err", err, 0);
    chk("wrst_blk_cnt", blk_cnt, 0);
    rst = 1'b0;
    core_ready = 1'b1; core_dout = {$urandom, $urandom};
    tick;
    core_ready = 1'b0;
    chk("late_ready_out_valid", out_valid, 0);
    chk("late_ready_busy", busy, 0);
    chk("late_ready_out_data", out_data, 0);
    key_m = '0; iv_m = '0; chain_m = '0; cbc_m = 1'b0; err_m = 1'b0; cnt_m = 0;
    send_block({$urandom, $urandom}, 1'b0, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
Sequencing controller for the team's single-block DES encryption core, which is driven by a start/ready handshake and takes a 64-bit block and a 64-bit key. The controller accepts a stream of 64-bit plaintext blocks over valid/ready and applies ECB or CBC chaining (chain = IV, then previous ciphertext). It issues one core operation per block and returns ciphertext over valid/ready. A watchdog flags a core that never answers. It sits between the bus-side block FIFO and the DES core.

Parameters:
TIMEOUT_CYC, 64, max cycles from core_start to core_ready before error
CNT_W, 16, width of block counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_load  in  1  latch cfg_key/cfg_iv/cfg_cbc (honoured only in IDLE)
cfg_key  in  64  DES key
cfg_iv  in  64  CBC initial vector
cfg_cbc  in  1  1=CBC, 0=ECB
in_valid  in  1  plaintext valid
in_ready  out  1  controller accepts plaintext
in_data  in  64  plaintext block
in_last  in  1  last block of message
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts ciphertext
out_data  out  64  ciphertext block
out_last  out  1  echoes in_last of this block
core_start  out  1  one-cycle start pulse to DES core
core_din  out  64  block to core, held stable START..WAIT
core_key  out  64  key register, held stable
core_ready  in  1  core done pulse; core_dout valid this cycle
core_dout  in  64  core result
busy  out  1  state != IDLE
err  out  1  sticky timeout flag
blk_cnt  out  CNT_W  blocks completed since reset/cfg_load, wraps

Behaviour:
- Reset (rst high at edge): state=IDLE. All outputs 0: in_ready, out_valid, out_data, out_last, core_start, core_din, busy, err, blk_cnt. Key, IV, chain and cbc registers are 0. Reset overrides every other event in any state.
- States: IDLE, START, WAIT, OUT.
- IDLE: in_ready=1 unless cfg_load=1 in the same cycle.
  - cfg_load has priority: latch key/iv/cbc, set chain=cfg_iv, clear blk_cnt and err, in_ready=0 that cycle.
  - On in_valid&&in_ready: core_din <= cbc ? in_data^chain : in_data. Latch in_last. Go to START.
- START: core_start=1 for exactly this cycle. Clear watchdog. Go to WAIT.
- WAIT: core_start=0, watchdog increments each cycle.
  - On core_ready: out_data<=core_dout, out_last<=latched last. If cbc, chain <= last ? iv : core_dout. Go to OUT (out_valid=1 from next cycle).
  - If watchdog reaches TIMEOUT_CYC-1 with no core_ready: err<=1, block dropped, chain unchanged, go to IDLE.
- OUT: out_valid=1, out_data/out_last held until out_ready. On out_valid&&out_ready: out_valid<=0, blk_cnt++ (wraps at 2^CNT_W), go to IDLE.
- Throughput: no overlap between blocks.
- Latency: input handshake edge E0 → core_start high in cycle E0..E1 → ciphertext visible one cycle after core_ready.
- cfg_load outside IDLE: ignored. core_ready outside WAIT: ignored. in_valid outside IDLE: not accepted (in_ready=0).
- ECB: chain is never used or updated.
- in_last in CBC: chain reloads IV after that block, so the next message restarts from the IV.
- core_key always drives the latched key. core_din changes only on input acceptance.
- err is cleared only by rst or cfg_load. Operation continues after err.

Test Plan:
1. ECB: cfg key=133457799BBCDFF1, cbc=0; send 0123456789ABCDEF → core_din=0123456789ABCDEF, core_start one cycle, out_data=85E813540F0AB405, blk_cnt=1.
2. CBC chaining: iv=0, cbc=1; send 0123456789ABCDEF twice → 1st core_din=0123456789ABCDEF, 2nd core_din=84CB563386A179EA (prev ciphertext XOR plaintext).
3. in_last reload: iv=1111111111111111, 1st block in_last=1, 2nd block P → 2nd core_din=P^1111111111111111, out_last=1 only on 1st output.
4. Backpressure: hold out_ready=0 for 10 cycles → out_valid/out_data stable, in_ready=0, no second core_start; release → handshake, blk_cnt increments once.
5. Timeout: core model never asserts core_ready, TIMEOUT_CYC=8 → err=1 8 cycles after core_start, state IDLE, no out_valid; next block completes normally with err still 1.
6. Priority/reset: cfg_load and in_valid same IDLE cycle → in_ready=0, config latched, block accepted next cycle; rst asserted in WAIT → next cycle all outputs 0, late core_ready ignored.
